// File: rtl/pwm_symbol_decoder.sv
// Hysteresis pulse detector + width counter + restoring divider: symbol = round(width / ref).
// Result strobes CNT_W+2 edges after the falling-crossing sample; pulses starting while busy are dropped.
module pwm_symbol_decoder #(
   parameter int DATA_W    = 16,
   parameter int CNT_W     = 16,
   parameter int SYM_W     = 8,
   parameter int HYST      = 4,
   parameter int MIN_WIDTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic signed [DATA_W-1:0] ref_in,
   input  logic signed [DATA_W-1:0] data_in,
   output logic [SYM_W-1:0]         decoded_symbol,
   output logic                     symbol_valid,
   output logic [CNT_W-1:0]         width_out,
   output logic                     overflow,
   output logic                     busy,
   output logic                     sym_dropped
);

   localparam int NUM_W  = CNT_W + 1;
   localparam int ITER_W = $clog2(NUM_W + 1);
   localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
   localparam logic signed [DATA_W-1:0] HYST_NEG = -HYST_POS;
   localparam logic [NUM_W-1:0] SYM_MAX = NUM_W'((1 << SYM_W) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_WIDTH);

   typedef enum logic [2:0] {IDLE, ARMED, MEASURE, DIVIDE, OUTPUT} state_t;

   state_t              state_q, state_d;
   logic                lvl_q, lvl_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic [CNT_W-1:0]    width_q, width_d;
   logic [DATA_W-1:0]   ref_q, ref_d;
   // Numerator bits shift out of the top while quotient bits shift in at the bottom.
   logic [NUM_W-1:0]    shreg_q, shreg_d;
   logic [DATA_W-1:0]   rem_q, rem_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [SYM_W-1:0]    sym_q, sym_d;
   logic                vld_q, vld_d;
   logic [CNT_W-1:0]    wout_q, wout_d;
   logic                ovf_out_q, ovf_out_d;
   logic                drop_q, drop_d;

   logic                hi_smp, lo_smp, rise, fall, ref_ok, ge;
   logic [DATA_W:0]     rem_sh, div_ext;

   assign hi_smp  = (data_in >= HYST_POS);
   assign lo_smp  = (data_in <= HYST_NEG);
   assign rise    = enable && !lvl_q && hi_smp;
   assign fall    = enable && lvl_q && lo_smp;
   assign ref_ok  = !ref_q[DATA_W-1] && (ref_q != '0);
   assign rem_sh  = {rem_q, shreg_q[NUM_W-1]};
   assign div_ext = {1'b0, ref_q};
   assign ge      = (rem_sh >= div_ext);

   always_comb begin
      state_d   = state_q;
      lvl_d     = lvl_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      width_d   = width_q;
      ref_d     = ref_q;
      shreg_d   = shreg_q;
      rem_d     = rem_q;
      iter_d    = iter_q;
      sym_d     = sym_q;
      vld_d     = 1'b0;
      wout_d    = wout_q;
      ovf_out_d = ovf_out_q;
      drop_d    = 1'b0;

      if (enable) begin
         if (hi_smp)      lvl_d = 1'b1;
         else if (lo_smp) lvl_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            // Only a fresh low sample arms, so a pulse already in flight is never measured.
            if (enable && lo_smp) state_d = ARMED;
         end
         ARMED: begin
            if (rise) begin
               cnt_d   = CNT_W'(1);
               ovf_d   = 1'b0;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (fall) begin
               if (cnt_q < MIN_W) begin
                  state_d = ARMED;
               end else begin
                  width_d = cnt_q;
                  ref_d   = ref_in;
                  shreg_d = {1'b0, cnt_q} + NUM_W'(ref_in[DATA_W-1:1]);
                  rem_d   = '0;
                  iter_d  = '0;
                  state_d = DIVIDE;
               end
            end else if (enable) begin
               if (cnt_q == CNT_MAX) ovf_d = 1'b1;
               else                  cnt_d = cnt_q + 1'b1;
            end
         end
         DIVIDE: begin
            drop_d = rise;
            if (ref_ok) begin
               rem_d   = DATA_W'(ge ? (rem_sh - div_ext) : rem_sh);
               shreg_d = {shreg_q[NUM_W-2:0], ge};
            end else begin
               shreg_d = '1;
               ovf_d   = 1'b1;
            end
            iter_d = iter_q + 1'b1;
            if (iter_q == ITER_W'(NUM_W - 1)) state_d = OUTPUT;
         end
         OUTPUT: begin
            drop_d    = rise;
            vld_d     = 1'b1;
            wout_d    = width_q;
            sym_d     = (shreg_q > SYM_MAX) ? SYM_MAX[SYM_W-1:0] : shreg_q[SYM_W-1:0];
            ovf_out_d = ovf_q || (shreg_q > SYM_MAX);
            state_d   = lvl_d ? IDLE : ARMED;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         lvl_q     <= 1'b0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         width_q   <= '0;
         ref_q     <= '0;
         shreg_q   <= '0;
         rem_q     <= '0;
         iter_q    <= '0;
         sym_q     <= '0;
         vld_q     <= 1'b0;
         wout_q    <= '0;
         ovf_out_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lvl_q     <= lvl_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         width_q   <= width_d;
         ref_q     <= ref_d;
         shreg_q   <= shreg_d;
         rem_q     <= rem_d;
         iter_q    <= iter_d;
         sym_q     <= sym_d;
         vld_q     <= vld_d;
         wout_q    <= wout_d;
         ovf_out_q <= ovf_out_d;
         drop_q    <= drop_d;
      end
   end

   assign decoded_symbol = sym_q;
   assign symbol_valid   = vld_q;
   assign width_out      = wout_q;
   assign overflow       = ovf_out_q;
   assign busy           = (state_q == DIVIDE) || (state_q == OUTPUT);
   assign sym_dropped    = drop_q;

endmodule
